// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types for the trace path: item layout, tags and widths.
// Used by trace_buffer and trace_fifo_ram.
package continuous_monitoring_system_pkg;

  localparam int TRACE_PC_WIDTH           = 64;
  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int TRACE_ITEM_WIDTH         = 98;

  typedef enum logic [1:0] {
    TAG_INSTR    = 2'b00,
    TAG_OVERFLOW = 2'b01
  } trace_item_tag_e;

  typedef struct packed {
    trace_item_tag_e                     tag;
    logic [TRACE_PC_WIDTH-1:0]           pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
  } trace_item_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/trace_fifo_ram.sv
// Trace item storage: two write ports (second only for marker pairs),
// asynchronous read. Contents are never reset.
module trace_fifo_ram
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_we0,
  input  logic [AW-1:0]               i_waddr0,
  input  logic [TRACE_ITEM_WIDTH-1:0] i_wdata0,
  input  logic                        i_we1,
  input  logic [AW-1:0]               i_waddr1,
  input  logic [TRACE_ITEM_WIDTH-1:0] i_wdata1,
  input  logic [AW-1:0]               i_raddr,
  output logic [TRACE_ITEM_WIDTH-1:0] o_rdata
);

  logic [TRACE_ITEM_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// FWFT buffer for filtered trace items with overflow accounting.
// Optional TRACE_BUFFER_OVERFLOW_MARKER_EN inserts a marker after losses.
module trace_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pc_valid,
  input  logic [TRACE_PC_WIDTH-1:0]           pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] next_instr,
  input  logic                                drop_instr,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [TRACE_ITEM_WIDTH-1:0]         m_data,
  output logic                                almost_full,
  output logic [$clog2(DEPTH):0]              level,
  output logic [15:0]                         overflow_count,
  input  logic                                clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] L_DM2   = LW'(DEPTH - 2);
  localparam logic [LW-1:0] L_THR   = LW'(ALMOST_FULL_THRESHOLD);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_ovf;

  logic          w_req;
  logic          w_pop;
  logic          w_acc;
  logic          w_loss;
  logic          w_mark;
  trace_item_t   w_instr_item;
  trace_item_t   w_wdata0;
  logic [TRACE_ITEM_WIDTH-1:0] w_rdata;

  assign w_req  = pc_valid & ~drop_instr;
  assign w_pop  = m_valid & m_ready;
  assign w_loss = w_req & ~w_acc;

  assign w_instr_item.tag   = TAG_INSTR;
  assign w_instr_item.pc    = pc;
  assign w_instr_item.instr = next_instr;

`ifdef TRACE_BUFFER_OVERFLOW_MARKER_EN
  logic        r_pending;
  logic [15:0] r_lost;
  trace_item_t w_mark_item;

  // While a marker is owed, keep room for marker plus instruction.
  assign w_mark = r_pending & (r_level <= L_DM2);
  assign w_acc  = w_req & (r_pending ? (r_level <= L_DM2)
                                     : (r_level <  L_DEPTH));

  assign w_mark_item.tag   = TAG_OVERFLOW;
  assign w_mark_item.pc    = {{(TRACE_PC_WIDTH-16){1'b0}}, r_lost};
  assign w_mark_item.instr = '0;
  assign w_wdata0 = w_mark ? w_mark_item : w_instr_item;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_lost    <= '0;
    end else if (w_mark) begin
      r_pending <= 1'b0;
      r_lost    <= '0;
    end else if (w_loss) begin
      r_pending <= 1'b1;
      r_lost    <= sat_inc16(r_lost);
    end
  end
`else
  assign w_mark   = 1'b0;
  assign w_acc    = w_req & (r_level < L_DEPTH);
  assign w_wdata0 = w_instr_item;
`endif

  trace_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .i_we0    (w_acc | w_mark),
    .i_waddr0 (r_wptr),
    .i_wdata0 (w_wdata0),
    .i_we1    (w_acc & w_mark),
    .i_waddr1 (r_wptr + AW'(1)),
    .i_wdata1 (w_instr_item),
    .i_raddr  (r_rptr),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_acc) + AW'(w_mark);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_level <= r_level + LW'(w_acc) + LW'(w_mark) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (clear_overflow) begin
      r_ovf <= {15'd0, w_loss};
    end else if (w_loss) begin
      r_ovf <= sat_inc16(r_ovf);
    end
  end

  assign m_valid        = (r_level != '0);
  assign m_data         = w_rdata;
  assign almost_full    = (r_level >= L_THR);
  assign level          = r_level;
  assign overflow_count = r_ovf;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed vector bench for trace_buffer at DEPTH=8, threshold 6.
// Marker scenario runs only when TRACE_BUFFER_OVERFLOW_MARKER_EN is set.
module tb_trace_buffer;
  import continuous_monitoring_system_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] next_instr;
  logic        drop_instr;
  logic        m_valid;
  logic        m_ready;
  logic [97:0] m_data;
  logic        almost_full;
  logic [3:0]  level;
  logic [15:0] overflow_count;
  logic        clear_overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trace_buffer #(.DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .next_instr     (next_instr),
    .drop_instr     (drop_instr),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .almost_full    (almost_full),
    .level          (level),
    .overflow_count (overflow_count),
    .clear_overflow (clear_overflow)
  );

  typedef struct {
    logic        pv;
    logic        drop;
    logic        rdy;
    logic        clr;
    logic [63:0] pc;
    logic [3:0]  lvl;
    logic        vld;
    logic        af;
    logic [15:0] ovf;
    logic        chk;
    logic [63:0] hpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [97:0] mk(input logic [1:0] tag,
                                     input logic [63:0] p,
                                     input logic [31:0] ins);
    return {tag, p, ins};
  endfunction

  function automatic logic [31:0] ins_of(input logic [63:0] p);
    return p[31:0] ^ 32'h13;
  endfunction

  task automatic add(input logic pv, input logic drop, input logic rdy,
                     input logic clr, input logic [63:0] p,
                     input int lvl, input logic vld, input int ovf,
                     input logic chk, input logic [63:0] hpc);
    vec_t v;
    v.pv = pv; v.drop = drop; v.rdy = rdy; v.clr = clr; v.pc = p;
    v.lvl = 4'(lvl); v.vld = vld; v.af = (lvl >= 6);
    v.ovf = 16'(ovf); v.chk = chk; v.hpc = hpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic drop, input logic rdy,
                       input logic clr, input logic [63:0] p,
                       input logic [31:0] ins);
    pc_valid = pv; drop_instr = drop; m_ready = rdy;
    clear_overflow = clr; pc = p; next_instr = ins;
  endtask

  task automatic step(input logic pv, input logic rdy,
                      input logic [63:0] p, input logic [31:0] ins);
    @(negedge clk);
    drive(pv, 1'b0, rdy, 1'b0, p, ins);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    logic [97:0] exp_q[$];

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);

    // scenario 1: three writes, then drain
    add(1, 0, 0, 0, 64'h100, 1, 1, 0, 1, 64'h100);
    add(1, 0, 0, 0, 64'h104, 2, 1, 0, 1, 64'h100);
    add(1, 0, 0, 0, 64'h108, 3, 1, 0, 1, 64'h100);
    add(0, 0, 1, 0, 64'h0,   2, 1, 0, 1, 64'h104);
    add(0, 0, 1, 0, 64'h0,   1, 1, 0, 1, 64'h108);
    add(0, 0, 1, 0, 64'h0,   0, 0, 0, 0, 64'h0);
    // scenario 2: alternate drop, consumer always ready
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0)
        add(1, 1, 1, 0, 64'h200 + 64'(4*k), 0, 0, 0, 0, 64'h0);
      else
        add(1, 0, 1, 0, 64'h200 + 64'(4*k), 1, 1, 0, 1,
            64'h200 + 64'(4*k));
    end
    add(0, 0, 1, 0, 64'h0, 0, 0, 0, 0, 64'h0);
    // scenario 3: overfill by two, then clear coinciding with a loss
    for (int k = 0; k < 10; k++)
      add(1, 0, 0, 0, 64'h300 + 64'(4*k), (k < 8) ? k + 1 : 8, 1,
          (k < 8) ? 0 : k - 7, 1, 64'h300);
    add(1, 0, 0, 1, 64'h3f0, 8, 1, 1, 1, 64'h300);

    #12;
    chk("rst_valid", 128'(m_valid), 128'(1'b0));
    chk("rst_level", 128'(level), 128'(4'd0));
    chk("rst_af", 128'(almost_full), 128'(1'b0));
    chk("rst_ovf", 128'(overflow_count), 128'(16'd0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].drop, vecs[i].rdy, vecs[i].clr,
            vecs[i].pc, ins_of(vecs[i].pc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_level", i), 128'(level), 128'(vecs[i].lvl));
      chk($sformatf("v%0d_valid", i), 128'(m_valid), 128'(vecs[i].vld));
      chk($sformatf("v%0d_af", i), 128'(almost_full), 128'(vecs[i].af));
      chk($sformatf("v%0d_ovf", i), 128'(overflow_count),
          128'(vecs[i].ovf));
      if (vecs[i].chk)
        chk($sformatf("v%0d_data", i), 128'(m_data),
            128'(mk(2'b00, vecs[i].hpc, ins_of(vecs[i].hpc))));
    end

    // drain to level 5 (bounded), then reset asynchronously mid-stream
    done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) begin
      step(1'b0, 1'b1, 64'h0, 32'h0);
      if (level == 4'd5) done = 1'b1;
    end
    chk("pre_rst_level", 128'(level), 128'(4'd5));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(m_valid), 128'(1'b0));
    chk("async_level", 128'(level), 128'(4'd0));
    chk("async_ovf", 128'(overflow_count), 128'(16'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 64'h500, ins_of(64'h500));
    chk("post_rst_level", 128'(level), 128'(4'd1));
    chk("post_rst_data", 128'(m_data),
        128'(mk(2'b00, 64'h500, ins_of(64'h500))));
    step(1'b0, 1'b1, 64'h0, 32'h0);
    chk("post_rst_empty", 128'(m_valid), 128'(1'b0));

`ifdef TRACE_BUFFER_OVERFLOW_MARKER_EN
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b0, 64'h600 + 64'(4*k), ins_of(64'h600 + 64'(4*k)));
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 64'h680 + 64'(4*k), ins_of(64'h680));
    chk("mk_ovf", 128'(overflow_count), 128'(16'd3));
    chk("mk_full", 128'(level), 128'(4'd8));
    step(1'b0, 1'b1, 64'h0, 32'h0);
    step(1'b0, 1'b1, 64'h0, 32'h0);
    chk("mk_lvl6", 128'(level), 128'(4'd6));
    step(1'b1, 1'b0, 64'h700, 32'h00000067);
    chk("mk_lvl8", 128'(level), 128'(4'd8));
    for (int k = 2; k < 8; k++)
      exp_q.push_back(mk(2'b00, 64'h600 + 64'(4*k),
                         ins_of(64'h600 + 64'(4*k))));
    exp_q.push_back(mk(2'b01, 64'd3, 32'd0));
    exp_q.push_back(mk(2'b00, 64'h700, 32'h00000067));
    foreach (exp_q[i]) begin
      chk($sformatf("mk_item%0d", i), 128'(m_data), 128'(exp_q[i]));
      step(1'b0, 1'b1, 64'h0, 32'h0);
    end
    chk("mk_empty", 128'(level), 128'(4'd0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Buffers trace items that survive `trace_filter` and hands them to the host-side collector over a valid/ready stream. Sits directly downstream of `trace_filter`. Each cycle it samples the same `pc_valid`/`next_instr` the filter sees plus the filter's `drop_instr`, and stores non-dropped items in a first-word-fall-through FIFO. It raises `almost_full` for back-pressure toward the core and counts items lost to overflow.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `ALMOST_FULL_THRESHOLD`, DEPTH-4: level at which `almost_full` asserts; range 1..DEPTH.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_valid` in 1: current cycle carries a retired instruction.
- `pc` in TRACE_PC_WIDTH (64): program counter of that instruction.
- `next_instr` in RISC_V_INSTRUCTION_WIDTH (32): instruction word.
- `drop_instr` in 1: filter verdict for the same cycle; 1 = discard.
- `m_valid` out 1: head item available.
- `m_ready` in 1: consumer takes head item when `m_valid`.
- `m_data` out TRACE_ITEM_WIDTH: head item, `{tag[1:0], pc[63:0], instr[31:0]}`.
- `almost_full` out 1: level ≥ ALMOST_FULL_THRESHOLD.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow_count` out 16: saturating total of lost items.
- `clear_overflow` in 1: synchronous clear of `overflow_count`.

## Operation
- Write request: `pc_valid & ~drop_instr`. Item tag = TAG_INSTR (2'b00).
- Pop: `m_valid & m_ready` advances the read pointer.
- Accept rule: write only if registered `level < DEPTH`. A pop in the same cycle does not free a slot for that cycle's write.
- Lost item: write request refused. `overflow_count` increments and saturates at 16'hFFFF.
- `clear_overflow` zeroes the count. If a loss occurs in the same cycle, the result is 1.
- Simultaneous write and pop: `level` unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is tracked separately.
- Reset, including mid-operation: pointers, `level`, `overflow_count` and the marker state are zeroed. FIFO contents are discarded; RAM is not cleared.

## Timing
- Reset values: `m_valid`=0, `m_data` undefined (don't-care), `almost_full`=0, `level`=0, `overflow_count`=0.
- Write-to-output latency is 1 cycle: an item accepted at edge N gives `m_valid`=1 after edge N when the FIFO was empty.
- `m_data` is driven combinationally from the RAM at the read pointer and is stable while `m_valid & ~m_ready`.
- `almost_full` and `level` derive from the registered count and update one edge after the causing write or pop.
- `m_valid` never deasserts without a pop.

## Configuration
- `TRACE_BUFFER_OVERFLOW_MARKER_EN` defined:
  - Sticky `overflow_pending` sets on any loss.
  - A 16-bit `lost_since_marker` counter (saturating) runs alongside.
  - While pending, writes require free slots ≥2 (`level ≤ DEPTH-2`). Otherwise the instruction is lost and counted.
  - When free ≥2 while pending, a marker is written: tag TAG_OVERFLOW (2'b01), `pc[15:0]`=lost_since_marker, other fields 0.
  - Marker behaviour in that cycle:
    - If an instruction write coincides, it is written in the following slot; the write pointer advances by 2 and `level` increases by 2 (net 1 with a pop).
    - Pending and `lost_since_marker` clear.
  - A marker is therefore always written before the first instruction after a loss.
- Not defined: no marker logic, no pending state; tag is always TAG_INSTR.

## Structure
- The following live in `continuous_monitoring_system_pkg`:
  - `TRACE_PC_WIDTH` (64)
  - `TRACE_ITEM_WIDTH` (98)
  - `trace_item_tag_e` (TAG_INSTR, TAG_OVERFLOW)
  - `trace_item_t` packed struct
- One sub-module, `trace_fifo_ram`: DEPTH×TRACE_ITEM_WIDTH storage with two write ports (second used only for the marker pair) and an asynchronous read port.
- Pointer, level and overflow logic stays in `trace_buffer`.

## Test plan
All scenarios use DEPTH=8 and ALMOST_FULL_THRESHOLD=6.
- Reset, then 3 items with `drop_instr`=0, `m_ready`=0:
  - Expected: `level`=3 one edge after the third write; `m_data` = first item; `almost_full`=0.
- Alternate `drop_instr`=1/0 over 10 cycles with `m_ready`=1:
  - Expected: exactly 5 items emerge, in order, each 1 cycle after acceptance.
- 10 writes, `m_ready`=0:
  - Expected: `level`=8, `almost_full`=1 from level 6, `overflow_count`=2.
  - Then `clear_overflow` coinciding with another loss: `overflow_count`=1.
- Macro on, fill 8 + lose 3, pop 2, then write 32'h00000067 in the same cycle the marker goes in:
  - Expected: marker tag 2'b01 with `pc[15:0]`=3, then the JALR item, `level`=8.
- Reset asserted mid-stream with `level`=5:
  - Expected: asynchronously `m_valid`=0, `level`=0, `overflow_count`=0; the next write appears alone.
